// File: rtl/l1_ahb_mtx_pkg.sv
// l1_ahb_mtx_pkg: AHB transfer-type and response encodings shared by the L1 bus-matrix blocks.
package l1_ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_t;

    // NONSEQ and SEQ are the only transfer types that carry real work.
    function automatic logic is_xfer(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/l1_ahb_mtx_hold_reg.sv
// l1_ahb_mtx_hold_reg: holding register for one stalled address phase plus its pending flag.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : master presents a NONSEQ/SEQ that completes its address phase
//   i_accept       : output stage takes the transfer currently on the decoder bus
//   i_d / o_q      : packed address-phase fields in / held copy out
//   o_pend         : held copy is valid and must be replayed
module l1_ahb_mtx_hold_reg #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_accept,
    input  logic [DW-1:0] i_d,
    output logic          o_pend,
    output logic [DW-1:0] o_q
);
    logic          r_pend;
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 1'b0;
            r_q    <= '0;
        end else begin
            if (!r_pend && i_load)
                r_q <= i_d;
            // While pending, only the replay's acceptance clears it; otherwise only
            // a transfer the output stage cannot take right now sets it.
            r_pend <= r_pend ? !i_accept : (i_load && !i_accept);
        end
    end

    assign o_pend = r_pend;
    assign o_q    = r_q;

endmodule

// File: rtl/l1_ahb_mtx_in_stg.sv
// l1_ahb_mtx_in_stg: per-master input stage of the L1 AHB matrix; holds and replays stalled address phases.
//   HCLK, HRESETn           : clock, async active-low reset
//   HSELS..HREADYS          : master-side AHB slave port inputs
//   active_dec              : target output stage accepts this port now
//   readyout_dec, resp_dec  : data-phase target's HREADYOUT/HRESP
//   sel_dec..ready_dec      : address phase presented to the decoder
//   HREADYOUTS, HRESPS      : ready/response returned to the master
module l1_ahb_mtx_in_stg
    import l1_ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PROT_W = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [PROT_W-1:0] HPROTS,
    input  logic              HREADYS,
    input  logic              active_dec,
    input  logic              readyout_dec,
    input  logic [1:0]        resp_dec,
    output logic              sel_dec,
    output logic [ADDR_W-1:0] addr_dec,
    output logic [1:0]        trans_dec,
    output logic              write_dec,
    output logic [2:0]        size_dec,
    output logic [2:0]        burst_dec,
    output logic [PROT_W-1:0] prot_dec,
    output logic              ready_dec,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS
);
    localparam int DW = ADDR_W + 2 + 1 + 3 + 3 + PROT_W;

    logic              w_load;
    logic              w_accept;
    logic              w_pend;
    logic [DW-1:0]     w_hold;
    logic [ADDR_W-1:0] w_h_addr;
    logic [1:0]        w_h_trans;
    logic              w_h_write;
    logic [2:0]        w_h_size;
    logic [2:0]        w_h_burst;
    logic [PROT_W-1:0] w_h_prot;
    logic              r_dphase;

    assign w_load = HSELS && is_xfer(HTRANSS) && HREADYS;

    l1_ahb_mtx_hold_reg #(.DW(DW)) u_hold (
        .i_clk    (HCLK),
        .i_rst_n  (HRESETn),
        .i_load   (w_load),
        .i_accept (w_accept),
        .i_d      ({HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS}),
        .o_pend   (w_pend),
        .o_q      (w_hold)
    );

    assign {w_h_addr, w_h_trans, w_h_write, w_h_size, w_h_burst, w_h_prot} = w_hold;

    // A held transfer owns the decoder bus; the master's live inputs are ignored until it is accepted.
    always_comb begin
        sel_dec   = w_pend ? 1'b1      : HSELS;
        addr_dec  = w_pend ? w_h_addr  : HADDRS;
        trans_dec = w_pend ? w_h_trans : (HSELS ? HTRANSS : HT_IDLE);
        write_dec = w_pend ? w_h_write : HWRITES;
        size_dec  = w_pend ? w_h_size  : HSIZES;
        burst_dec = w_pend ? w_h_burst : HBURSTS;
        prot_dec  = w_pend ? w_h_prot  : HPROTS;
        ready_dec = w_pend ? 1'b1      : HREADYS;
    end

    assign w_accept = active_dec && ready_dec && sel_dec && is_xfer(trans_dec);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_dphase <= 1'b0;
        else if (ready_dec)
            r_dphase <= w_accept;
    end

    assign HREADYOUTS = w_pend ? 1'b0    : (r_dphase ? readyout_dec : 1'b1);
    assign HRESPS     = w_pend ? HR_OKAY : (r_dphase ? resp_dec     : HR_OKAY);

    // Holding only happens with ready_dec=1 and no accept, so the data phase is always closed by then.
    a_pend_dphase: assert property (@(posedge HCLK) disable iff (!HRESETn) !(w_pend && r_dphase));
    // HREADYOUTS is low while pending, so a well-behaved master cannot complete another address phase.
    a_no_load_pend: assert property (@(posedge HCLK) disable iff (!HRESETn) !(w_pend && w_load));

endmodule
